// File: rtl/mux2_1.sv
// 2:1 multiplexer built from delayed gates, plus a registered copy of
// the result and a valid flag that tracks reset.
//
// Ports:
//   clk      rising-edge clock for out_q / valid_q
//   reset    synchronous active-high reset (registered outputs only)
//   i[1:0]   data inputs; i[0] chosen when sel=0, i[1] when sel=1
//   sel      select
//   out      combinational mux result, independent of clk/reset
//   out_q    out captured on each rising edge (0 after reset)
//   valid_q  1 once out_q holds a value captured since reset released
`timescale 1ns/10ps

module mux2_1 #(
    parameter int GATE_DELAY = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i,
    input  logic       sel,
    output logic       out,
    output logic       out_q,
    output logic       valid_q
);

    logic selN;
    logic andHi;
    logic andLo;

    // Gate-level datapath: each assignment is one primitive gate with
    // its own propagation delay. The longest path is
    // sel -> inverter -> AND -> OR, i.e. three gate delays.
    not #(GATE_DELAY) gInv (selN, sel);
    and #(GATE_DELAY) gHi (andHi, sel, i[1]);
    and #(GATE_DELAY) gLo (andLo, selN, i[0]);
    or  #(GATE_DELAY) gOr (out, andHi, andLo);

    // Registered copy. Reset discards the capture on that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux2_1.sv
// Self-checking bench for mux2_1: directed reset/latency/delay checks,
// exhaustive truth table, inverting use and random stepping.
`timescale 1ns/10ps

module tb_mux2_1;

    localparam int GD = 50;

    logic       clk;
    logic       reset;
    logic [1:0] i;
    logic       sel;
    logic       out;
    logic       out_q;
    logic       valid_q;

    int errors = 0;
    int checks = 0;

    mux2_1 #(.GATE_DELAY(GD)) dut (
        .clk     (clk),
        .reset   (reset),
        .i       (i),
        .sel     (sel),
        .out     (out),
        .out_q   (out_q),
        .valid_q (valid_q)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    // Reference: pick the input addressed by sel.
    function automatic logic refMux(input logic s, input logic [1:0] v);
        return v[s];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #100;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] v;
        logic       b;
        logic       c;
        logic       rs;
        logic       expOut;

        reset = 1'b1;
        sel   = 1'b1;
        i     = 2'b10;

        // Reset held for two edges; out unaffected.
        nextEdge();
        chk("rst_out_e1", out, 1'b1);
        nextEdge();
        chk("rst_out_e2", out, 1'b1);
        chk("rst_outq", out_q, 1'b0);
        chk("rst_valid", valid_q, 1'b0);
        reset = 1'b0;
        nextEdge();
        chk("rel_outq", out_q, 1'b1);
        chk("rel_valid", valid_q, 1'b1);

        // Latency: sel changes mid-cycle, out_q waits for the edge.
        #200;
        sel = 1'b0;
        #100;
        chk("lat_hold", out_q, 1'b1);
        nextEdge();
        chk("lat_out", out, 1'b0);
        chk("lat_outq", out_q, 1'b0);

        // Mid-stream reset between edges.
        sel = 1'b1;
        nextEdge();
        chk("mid_outq_pre", out_q, 1'b1);
        chk("mid_valid_pre", valid_q, 1'b1);
        #200;
        reset = 1'b1;
        #100;
        chk("mid_outq_hold", out_q, 1'b1);
        chk("mid_valid_hold", valid_q, 1'b1);
        nextEdge();
        chk("mid_outq_rst", out_q, 1'b0);
        chk("mid_valid_rst", valid_q, 1'b0);
        chk("mid_out", out, 1'b1);
        reset = 1'b0;
        nextEdge();
        chk("mid_valid_back", valid_q, 1'b1);

        // Propagation delay: sel 0->1 with i=10.
        sel = 1'b0;
        i   = 2'b10;
        #200;
        chk("dly_start", out, 1'b0);
        sel = 1'b1;
        #(2*GD - 1);
        chk("dly_early", out, 1'b0);
        #(GD + 1);
        chk("dly_settled", out, 1'b1);

        // Exhaustive truth table.
        for (int k = 0; k < 8; k++) begin
            v   = k[2:0];
            sel = v[2];
            i   = v[1:0];
            #6000;
            chk($sformatf("exh_out_%0d", k), out, refMux(v[2], v[1:0]));
            chk($sformatf("exh_outq_%0d", k), out_q, refMux(v[2], v[1:0]));
        end

        // Inverting use: i={~b,b}, sel=control.
        for (int k = 0; k < 4; k++) begin
            v   = k[2:0];
            b   = v[0];
            c   = v[1];
            i   = {~b, b};
            sel = c;
            #1000;
            chk($sformatf("inv_b%0d_c%0d", b, c), out, b ^ c);
        end

        // Random stepping with occasional reset.
        nextEdge();
        for (int k = 0; k < 40; k++) begin
            v      = 3'($urandom);
            rs     = ($urandom_range(0, 7) == 0);
            sel    = v[2];
            i      = v[1:0];
            reset  = rs;
            expOut = refMux(v[2], v[1:0]);
            #300;
            chk($sformatf("rnd_out_%0d", k), out, expOut);
            nextEdge();
            chk($sformatf("rnd_outq_%0d", k), out_q, rs ? 1'b0 : expOut);
            chk($sformatf("rnd_valid_%0d", k), valid_q, !rs);
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
